bmp180_collector: RTL and testbench
===================================

BMP180_COLLECTOR -- requirements
Module: bmp180_collector

Interface
REQ-001 Parameter ID_EXPECTED, default 8'h55: chip ID value that makes id_ok true.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 arm  input  1  one-cycle pulse; starts a capture in the mode given on mode.
REQ-005 mode  input  2  capture type: 0=ID (1 byte), 1=CAL (22 bytes), 2=TEMP (2 bytes), 3=PRESS (3 bytes).
REQ-006 oss  input  2  pressure oversampling setting, sampled with arm.
REQ-007 abort  input  1  one-cycle pulse; cancels an active capture.
REQ-008 received  input  1  one-cycle strobe from the I2C master; a new byte is valid on datareceive.
REQ-009 datareceive  input  8  byte delivered by the I2C master.
REQ-010 cal_sel  input  4  calibration word index 0..10; 11..15 read as 0.
REQ-011 busy  output  1  high while a capture is active.
REQ-012 done  output  1  one-cycle pulse when a capture completes.
REQ-013 chip_id  output  8  last committed ID byte.
REQ-014 id_ok  output  1  chip_id == ID_EXPECTED, registered.
REQ-015 ut  output  16  last committed uncompensated temperature.
REQ-016 up  output  19  last committed uncompensated pressure.
REQ-017 cal_valid  output  1  all 22 calibration bytes captured.
REQ-018 cal_word  output  16  calibration word selected by cal_sel, combinational read.
REQ-019 err  output  1  sticky protocol error flag.

Function
REQ-020 The FSM SHALL have the states IDLE, COLLECT and DONE.
REQ-021 IDLE->COLLECT on arm: latch mode and oss, clear the byte counter, clear err; busy=1 from the next cycle.
REQ-022 Expected byte count SHALL be 1, 22, 2 or 3 for modes 0..3.
REQ-023 In COLLECT, each received SHALL store datareceive at index cnt and increment cnt; the first byte is the MSB.
REQ-024 The received that delivers byte count-1 SHALL commit the result and move to DONE; done=1 for exactly one cycle in DONE, then IDLE; busy=0 in DONE.
REQ-025 ID commit: chip_id <= byte0; id_ok is updated in the same cycle.
REQ-026 TEMP commit: ut <= {b0,b1}.
REQ-027 PRESS commit: up <= {b0,b1,b2} >> (8-oss), zero-extended/truncated to 19 bits.
REQ-028 CAL: bytes are written directly into a 22-byte array; cal_valid is cleared at arm and set at commit.
REQ-029 cal_word(k) SHALL be {byte[2k],byte[2k+1]} when cal_valid=1 and k<=10, else 16'h0000.
REQ-030 ID/TEMP/PRESS bytes are held in shadow registers; visible outputs change only at commit.
REQ-031 arm while busy or in DONE SHALL be ignored.
REQ-032 received in IDLE or DONE SHALL be ignored and SHALL set err.
REQ-033 received in the same cycle as an accepted arm SHALL be ignored and SHALL NOT set err.
REQ-034 abort in COLLECT SHALL return to IDLE next cycle with no commit and no done pulse; prior committed outputs are kept; an aborted CAL capture leaves cal_valid=0.
REQ-035 abort and received in the same cycle: abort wins and the byte is discarded.
REQ-036 abort in IDLE or DONE SHALL have no effect.

Reset
REQ-037 reset SHALL force IDLE, cnt=0, busy=0, done=0, chip_id=0, id_ok=0, ut=0, up=0, cal_valid=0 and err=0; array contents are don't-care.
REQ-038 reset SHALL take priority over arm, abort and received, including in the middle of a capture.

Verification
REQ-039 arm mode=0, then received 8'h55 -> done after 1 cycle, chip_id=8'h55, id_ok=1, busy=0.
REQ-040 arm mode=3 oss=3, then bytes 8'h5D,8'h23,8'hC0 -> up=19'h2E91E; ut is unchanged.
REQ-041 arm mode=1, 22 bytes 8'h00..8'h15 -> cal_valid=1; cal_sel=0 gives 16'h0001, cal_sel=10 gives 16'h1415, cal_sel=12 gives 0.
REQ-042 arm mode=2, one byte, then abort -> no done pulse, ut keeps its old value, busy=0 in the next cycle.
REQ-043 received in IDLE -> err=1; a later arm clears err.
REQ-044 reset asserted after 10 CAL bytes -> all outputs reset; a following mode=2 capture of 8'h6C,8'hFA gives ut=16'h6CFA.

Source files
------------

// File: rtl/bmp180_collector.sv
// BMP180 readout collector: gathers ID, calibration, temperature and pressure
// bytes streamed by an I2C master and commits them as decoded results.
module bmp180_collector #(
  parameter logic [7:0] ID_EXPECTED = 8'h55
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arm,
  input  logic [1:0]  mode,
  input  logic [1:0]  oss,
  input  logic        abort,
  input  logic        received,
  input  logic [7:0]  datareceive,
  input  logic [3:0]  cal_sel,
  output logic        busy,
  output logic        done,
  output logic [7:0]  chip_id,
  output logic        id_ok,
  output logic [15:0] ut,
  output logic [18:0] up,
  output logic        cal_valid,
  output logic [15:0] cal_word,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  localparam logic [1:0] ModeId    = 2'd0;
  localparam logic [1:0] ModeCal   = 2'd1;
  localparam logic [1:0] ModeTemp  = 2'd2;
  localparam logic [1:0] ModePress = 2'd3;

  state_e      state_q;
  logic [1:0]  mode_q;
  logic [1:0]  oss_q;
  logic [4:0]  cnt_q;
  logic [7:0]  b0_q;
  logic [7:0]  b1_q;
  logic [7:0]  cal_mem [22];

  logic [4:0]  last_idx;
  logic        is_last;
  logic        take_byte;
  logic [23:0] press_raw;
  logic [23:0] press_shift;
  logic [3:0]  shamt;
  logic [4:0]  idx_hi;
  logic [4:0]  idx_lo;

  // Index of the final byte for the latched capture type.
  always_comb begin
    last_idx = 5'd0;
    unique case (mode_q)
      ModeId:    last_idx = 5'd0;
      ModeCal:   last_idx = 5'd21;
      ModeTemp:  last_idx = 5'd1;
      ModePress: last_idx = 5'd2;
      default:   last_idx = 5'd0;
    endcase
  end

  assign is_last   = (cnt_q == last_idx);
  assign take_byte = (state_q == StCollect) && !abort && received;

  // Final pressure byte is still on the bus when the result is committed.
  assign press_raw   = {b0_q, b1_q, datareceive};
  assign shamt       = 4'd8 - {2'b00, oss_q};
  assign press_shift = press_raw >> shamt;

  // Capture FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      mode_q    <= ModeId;
      oss_q     <= 2'd0;
      cnt_q     <= 5'd0;
      b0_q      <= 8'h00;
      b1_q      <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      chip_id   <= 8'h00;
      id_ok     <= 1'b0;
      ut        <= 16'h0000;
      up        <= 19'h00000;
      cal_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (arm) begin
            // A byte arriving alongside an accepted arm is dropped silently.
            state_q <= StCollect;
            mode_q  <= mode;
            oss_q   <= oss;
            cnt_q   <= 5'd0;
            err     <= 1'b0;
            busy    <= 1'b1;
            if (mode == ModeCal) cal_valid <= 1'b0;
          end else if (received) begin
            err <= 1'b1;
          end
        end
        StCollect: begin
          if (abort) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else if (received) begin
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd0) b0_q <= datareceive;
            if (cnt_q == 5'd1) b1_q <= datareceive;
            if (is_last) begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
              unique case (mode_q)
                ModeId: begin
                  chip_id <= datareceive;
                  id_ok   <= (datareceive == ID_EXPECTED);
                end
                ModeCal:   cal_valid <= 1'b1;
                ModeTemp:  ut <= {b0_q, datareceive};
                ModePress: up <= press_shift[18:0];
                default:   ;
              endcase
            end
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
          if (received) err <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // Calibration bytes go straight into the array; contents need no reset.
  always_ff @(posedge clk) begin
    if (!reset && take_byte && (mode_q == ModeCal) && (cnt_q < 5'd22)) begin
      cal_mem[cnt_q] <= datareceive;
    end
  end

  assign idx_hi = {cal_sel, 1'b0};
  assign idx_lo = {cal_sel, 1'b1};

  // Combinational calibration word lookup, zero when invalid or out of range.
  always_comb begin
    cal_word = 16'h0000;
    if (cal_valid && (cal_sel <= 4'd10)) begin
      cal_word = {cal_mem[idx_hi], cal_mem[idx_lo]};
    end
  end

endmodule

// File: tb/tb_bmp180_collector.sv
// Self-checking bench for bmp180_collector: table-driven captures with a
// scoreboard of expected committed results, plus hand-written corner cases.
module tb_bmp180_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic [1:0]  mode;
  logic [1:0]  oss;
  logic        abort;
  logic        received;
  logic [7:0]  datareceive;
  logic [3:0]  cal_sel;
  logic        busy;
  logic        done;
  logic [7:0]  chip_id;
  logic        id_ok;
  logic [15:0] ut;
  logic [18:0] up;
  logic        cal_valid;
  logic [15:0] cal_word;
  logic        err;

  bmp180_collector #(.ID_EXPECTED(8'h55)) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .mode       (mode),
    .oss        (oss),
    .abort      (abort),
    .received   (received),
    .datareceive(datareceive),
    .cal_sel    (cal_sel),
    .busy       (busy),
    .done       (done),
    .chip_id    (chip_id),
    .id_ok      (id_ok),
    .ut         (ut),
    .up         (up),
    .cal_valid  (cal_valid),
    .cal_word   (cal_word),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  oss;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  chip;
    logic        idok;
    logic [15:0] ut;
    logic [18:0] up;
  } vec_t;

  typedef struct {
    logic [7:0]  chip;
    logic        idok;
    logic [15:0] ut;
    logic [18:0] up;
  } exp_t;

  vec_t vecs [8];
  exp_t sb [$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    received    = 1'b1;
    datareceive = b;
    tick();
    received    = 1'b0;
  endtask

  task automatic start(input logic [1:0] m, input logic [1:0] o);
    arm  = 1'b1;
    mode = m;
    oss  = o;
    tick();
    arm  = 1'b0;
    chk("busy_after_arm", {31'd0, busy}, 32'd1);
  endtask

  task automatic push_exp(input logic [7:0] c, input logic i, input logic [15:0] t,
                          input logic [18:0] p);
    exp_t e;
    e.chip = c;
    e.idok = i;
    e.ut   = t;
    e.up   = p;
    sb.push_back(e);
  endtask

  // Called right after the final byte: done must already be high.
  task automatic finish_check();
    exp_t e;
    int   n;
    chk("done_latency", {31'd0, done}, 32'd1);
    n = 0;
    while (!done && n < 4) begin
      tick();
      n++;
    end
    if (!done) begin
      chk("done_timeout", {31'd0, done}, 32'd1);
    end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("chip_id", {24'd0, chip_id}, {24'd0, e.chip});
      chk("id_ok", {31'd0, id_ok}, {31'd0, e.idok});
      chk("ut", {16'd0, ut}, {16'd0, e.ut});
      chk("up", {13'd0, up}, {13'd0, e.up});
      chk("busy_in_done", {31'd0, busy}, 32'd0);
    end
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    // mode, oss, bytes, then cumulative expected chip_id/id_ok/ut/up after commit
    vecs[0] = '{2'd0, 2'd0, 8'h55, 8'h00, 8'h00, 8'h55, 1'b1, 16'h0000, 19'h00000};
    vecs[1] = '{2'd3, 2'd3, 8'h5D, 8'h23, 8'hC0, 8'h55, 1'b1, 16'h0000, 19'h2E91E};
    vecs[2] = '{2'd2, 2'd0, 8'h6C, 8'hFA, 8'h00, 8'h55, 1'b1, 16'h6CFA, 19'h2E91E};
    vecs[3] = '{2'd0, 2'd0, 8'h12, 8'h00, 8'h00, 8'h12, 1'b0, 16'h6CFA, 19'h2E91E};
    vecs[4] = '{2'd3, 2'd0, 8'hFF, 8'hFF, 8'hFF, 8'h12, 1'b0, 16'h6CFA, 19'h0FFFF};
    vecs[5] = '{2'd3, 2'd2, 8'h80, 8'h00, 8'h01, 8'h12, 1'b0, 16'h6CFA, 19'h20000};
    vecs[6] = '{2'd2, 2'd1, 8'h00, 8'h01, 8'h00, 8'h12, 1'b0, 16'h0001, 19'h20000};
    vecs[7] = '{2'd3, 2'd3, 8'hFF, 8'hFF, 8'hFF, 8'h12, 1'b0, 16'h0001, 19'h7FFFF};

    reset = 1'b1;
    arm = 1'b0; mode = 2'd0; oss = 2'd0; abort = 1'b0;
    received = 1'b0; datareceive = 8'h00; cal_sel = 4'd0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_chip_id", {24'd0, chip_id}, 32'd0);
    chk("rst_id_ok", {31'd0, id_ok}, 32'd0);
    chk("rst_ut", {16'd0, ut}, 32'd0);
    chk("rst_up", {13'd0, up}, 32'd0);
    chk("rst_cal_valid", {31'd0, cal_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_cal_word", {16'd0, cal_word}, 32'd0);

    // Table-driven ID/TEMP/PRESS captures
    for (int i = 0; i < 8; i++) begin
      start(vecs[i].mode, vecs[i].oss);
      push_exp(vecs[i].chip, vecs[i].idok, vecs[i].ut, vecs[i].up);
      send_byte(vecs[i].b0);
      if (vecs[i].mode != 2'd0) begin
        chk("no_early_done", {31'd0, done}, 32'd0);
        send_byte(vecs[i].b1);
      end
      if (vecs[i].mode == 2'd3) send_byte(vecs[i].b2);
      finish_check();
    end

    // Calibration capture of bytes 0x00..0x15
    start(2'd1, 2'd0);
    chk("cal_cleared_at_arm", {31'd0, cal_valid}, 32'd0);
    push_exp(8'h12, 1'b0, 16'h0001, 19'h7FFFF);
    for (int i = 0; i < 22; i++) send_byte(8'(i));
    finish_check();
    chk("cal_valid", {31'd0, cal_valid}, 32'd1);
    cal_sel = 4'd0;  #1; chk("cal_word0", {16'd0, cal_word}, 32'h0001);
    cal_sel = 4'd5;  #1; chk("cal_word5", {16'd0, cal_word}, 32'h0A0B);
    cal_sel = 4'd10; #1; chk("cal_word10", {16'd0, cal_word}, 32'h1415);
    cal_sel = 4'd11; #1; chk("cal_word11", {16'd0, cal_word}, 32'h0000);
    cal_sel = 4'd12; #1; chk("cal_word12", {16'd0, cal_word}, 32'h0000);
    cal_sel = 4'd0;

    // Abort a TEMP capture after one byte
    start(2'd2, 2'd0);
    send_byte(8'hAA);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_no_done", {31'd0, done}, 32'd0);
    tick();
    chk("abort_no_done_later", {31'd0, done}, 32'd0);
    chk("abort_ut_kept", {16'd0, ut}, 32'h0001);

    // Abort and received together: abort wins
    start(2'd2, 2'd0);
    send_byte(8'hAA);
    abort = 1'b1; received = 1'b1; datareceive = 8'hBB;
    tick();
    abort = 1'b0; received = 1'b0;
    chk("abort_rx_busy", {31'd0, busy}, 32'd0);
    chk("abort_rx_done", {31'd0, done}, 32'd0);
    chk("abort_rx_err", {31'd0, err}, 32'd0);
    chk("abort_rx_ut", {16'd0, ut}, 32'h0001);

    // Stray byte in IDLE sets err; arm with a simultaneous byte clears it and drops the byte
    send_byte(8'h33);
    chk("err_idle_rx", {31'd0, err}, 32'd1);
    arm = 1'b1; mode = 2'd0; received = 1'b1; datareceive = 8'h77;
    tick();
    arm = 1'b0; received = 1'b0;
    chk("arm_rx_busy", {31'd0, busy}, 32'd1);
    chk("arm_clears_err", {31'd0, err}, 32'd0);
    push_exp(8'h55, 1'b1, 16'h0001, 19'h7FFFF);
    send_byte(8'h55);
    finish_check();
    chk("arm_rx_no_err", {31'd0, err}, 32'd0);

    // Arm while busy is ignored
    start(2'd2, 2'd0);
    send_byte(8'h11);
    arm = 1'b1; mode = 2'd0;
    tick();
    arm = 1'b0;
    chk("arm_busy_ignored", {31'd0, busy}, 32'd1);
    push_exp(8'h55, 1'b1, 16'h1122, 19'h7FFFF);
    send_byte(8'h22);
    finish_check();

    // Aborted CAL capture leaves cal_valid low
    start(2'd1, 2'd0);
    for (int i = 0; i < 3; i++) send_byte(8'hE0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_cal_valid", {31'd0, cal_valid}, 32'd0);
    chk("abort_cal_word", {16'd0, cal_word}, 32'd0);

    // Reset in the middle of a CAL capture
    start(2'd1, 2'd0);
    for (int i = 0; i < 10; i++) send_byte(8'(i));
    reset = 1'b1; received = 1'b1; datareceive = 8'h99;
    tick();
    reset = 1'b0; received = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_chip_id", {24'd0, chip_id}, 32'd0);
    chk("mid_rst_id_ok", {31'd0, id_ok}, 32'd0);
    chk("mid_rst_ut", {16'd0, ut}, 32'd0);
    chk("mid_rst_up", {13'd0, up}, 32'd0);
    chk("mid_rst_cal_valid", {31'd0, cal_valid}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    start(2'd2, 2'd0);
    push_exp(8'h00, 1'b0, 16'h6CFA, 19'h00000);
    send_byte(8'h6C);
    send_byte(8'hFA);
    finish_check();
    chk("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
